// File: rtl/msg_sender.sv
// msg_sender: streams a string from the message ROM into the UART TX byte
// interface, on behalf of two requesters.
//
// Requester 0 (command parser) has fixed priority over requester 1 (boot /
// status logic). On accept, the ROM string and length are latched. The bytes
// are then sent first-character-first. The ROM stores the last character in
// bits [7:0], so the first character sits at bits [8*len-1 -: 8].
//
// Optional feature: define MSG_CRLF_EN to append 0x0D 0x0A after every
// message, including empty ones. When it is undefined, exactly len bytes
// are sent.
//
// Parameters:
//   GUARD_CYCLES  cycles after each tx_start during which tx_busy is ignored
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req0_valid/id/ready       requester 0 handshake (higher priority)
//   req1_valid/id/ready       requester 1 handshake
//   rom_id                    id presented to the combinational string ROM
//   rom_string, rom_length    ROM data, last character in bits [7:0]
//   tx_data, tx_start         byte and one-cycle start strobe to UART TX
//   tx_busy                   UART TX busy
//   busy                      a message is in progress
//   done, done_src            one-cycle completion pulse and its requester

module msg_sender #(
    parameter int GUARD_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [1:0]   req0_id,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [1:0]   req1_id,
    output logic         req1_ready,
    output logic [1:0]   rom_id,
    input  logic [255:0] rom_string,
    input  logic [4:0]   rom_length,
    output logic [7:0]   tx_data,
    output logic         tx_start,
    input  logic         tx_busy,
    output logic         busy,
    output logic         done,
    output logic         done_src
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        DONE
`ifdef MSG_CRLF_EN
        ,
        CR,
        LF
`endif
    } state_t;

    localparam logic [7:0] GUARD_INIT = 8'(GUARD_CYCLES);

    state_t         state;
    logic [255:0]   str_q;
    logic [4:0]     len_q;
    logic [4:0]     idx_q;
    logic           src_q;
    logic [1:0]     id_q;
    logic [7:0]     guard_q;
`ifdef MSG_CRLF_EN
    // 0: string characters, 1: CR has been sent, 2: LF has been sent
    logic [1:0]     tail_q;
`endif

    logic           accept0;
    logic           accept1;
    logic [4:0]     sel;
    logic [7:0]     bit_off;
    logic [7:0]     cur_byte;
    logic           last_char;

    // Acceptance is combinational, so ready pulses in the same cycle in
    // which the ROM data is captured. Port 0 always wins a tie.
    assign accept0    = (state == IDLE) && req0_valid;
    assign accept1    = (state == IDLE) && !req0_valid && req1_valid;
    assign req0_ready = accept0;
    assign req1_ready = accept1;

    // The first character is the most significant occupied byte, so the
    // byte index counts down from len-1 as idx counts up.
    assign sel       = len_q - 5'd1 - idx_q;
    assign bit_off   = {sel, 3'b000};
    assign cur_byte  = str_q[bit_off +: 8];
    // Compare before incrementing, so a length of 31 never wraps idx.
    assign last_char = (idx_q == len_q - 5'd1);

    // While idle, the ROM sees the id of whichever request would win. After
    // accept it sees the latched id, so the ROM output stays stable for
    // the whole message.
    always_comb begin
        rom_id = id_q;
        if (state == IDLE) begin
            rom_id = req0_valid ? req0_id : req1_id;
        end
    end

    // Main sequencer. tx_start and done default low, so each one is a
    // single-cycle pulse. tx_data is written only when a byte is issued,
    // so it holds its value until the next tx_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            str_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            src_q    <= 1'b0;
            id_q     <= '0;
            guard_q  <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            done_src <= 1'b0;
`ifdef MSG_CRLF_EN
            tail_q   <= '0;
`endif
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept0 || accept1) begin
                        str_q <= rom_string;
                        len_q <= rom_length;
                        idx_q <= '0;
                        src_q <= accept1;
                        id_q  <= rom_id;
                        busy  <= 1'b1;
`ifdef MSG_CRLF_EN
                        tail_q <= 2'd0;
                        state  <= (rom_length != 5'd0) ? SEND : CR;
`else
                        state  <= (rom_length != 5'd0) ? SEND : DONE;
`endif
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_data  <= cur_byte;
                        tx_start <= 1'b1;
                        guard_q  <= GUARD_INIT;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // The TX raises busy only some cycles after tx_start.
                    // Do not trust its idle level until the guard expires.
                    if (guard_q != 8'd0) begin
                        guard_q <= guard_q - 8'd1;
                    end else if (!tx_busy) begin
`ifdef MSG_CRLF_EN
                        case (tail_q)
                            2'd0: begin
                                idx_q <= idx_q + 5'd1;
                                state <= last_char ? CR : SEND;
                            end
                            2'd1:    state <= LF;
                            default: state <= DONE;
                        endcase
`else
                        idx_q <= idx_q + 5'd1;
                        state <= last_char ? DONE : SEND;
`endif
                    end
                end
`ifdef MSG_CRLF_EN
                CR: begin
                    if (!tx_busy) begin
                        tx_data  <= 8'h0D;
                        tx_start <= 1'b1;
                        guard_q  <= GUARD_INIT;
                        tail_q   <= 2'd1;
                        state    <= WAIT;
                    end
                end
                LF: begin
                    if (!tx_busy) begin
                        tx_data  <= 8'h0A;
                        tx_start <= 1'b1;
                        guard_q  <= GUARD_INIT;
                        tail_q   <= 2'd2;
                        state    <= WAIT;
                    end
                end
`endif
                DONE: begin
                    done     <= 1'b1;
                    done_src <= src_q;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_sender.sv
// tb_msg_sender: directed testbench for msg_sender.
//
// The bench contains a behavioural ROM, a UART TX model that stays busy for
// 10 cycles per byte, and negedge monitors. The monitors log every
// transmitted byte and every done pulse. Expected byte streams come from
// string constants. When MSG_CRLF_EN is defined, each stream also gets a
// CR LF tail.

module tb_msg_sender;

    logic         clk;
    logic         rst;
    logic         req0_valid;
    logic [1:0]   req0_id;
    logic         req0_ready;
    logic         req1_valid;
    logic [1:0]   req1_id;
    logic         req1_ready;
    logic [1:0]   rom_id;
    logic [255:0] rom_string;
    logic [4:0]   rom_length;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         tx_busy;
    logic         busy;
    logic         done;
    logic         done_src;

    logic [255:0] special_str;
    logic [4:0]   special_len;
    logic         hold_busy;
    logic [3:0]   uart_cnt;

    int           checks;
    int           errors;
    int           tx_count;
    int           done_count;
    logic [7:0]   got_q[$];
    logic [7:0]   exp_q[$];
    logic         dsrc_q[$];

    msg_sender #(.GUARD_CYCLES(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_id    (req0_id),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_id    (req1_id),
        .req1_ready (req1_ready),
        .rom_id     (rom_id),
        .rom_string (rom_string),
        .rom_length (rom_length),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .done       (done),
        .done_src   (done_src)
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational string ROM. Id 1 is reprogrammable for the edge cases.
    always_comb begin
        rom_string = '0;
        rom_length = '0;
        case (rom_id)
            2'd0: begin rom_string = 256'("starting program");       rom_length = 5'd16; end
            2'd1: begin rom_string = special_str;                      rom_length = special_len; end
            2'd2: begin rom_string = 256'("error: invalid command"); rom_length = 5'd22; end
            default: begin rom_string = 256'("PONG");               rom_length = 5'd4; end
        endcase
    end

    // UART TX model: busy starts the cycle after tx_start and lasts 10 cycles.
    // hold_busy forces it busy to stall the sender.
    always @(posedge clk or posedge rst) begin
        if (rst)
            uart_cnt <= '0;
        else if (tx_start)
            uart_cnt <= 4'd10;
        else if (uart_cnt != 4'd0)
            uart_cnt <= uart_cnt - 4'd1;
    end
    assign tx_busy = (uart_cnt != 4'd0) || hold_busy;

    // Log transmitted bytes and done pulses away from the active edge
    always @(negedge clk) begin
        if (!rst && tx_start) begin
            got_q.push_back(tx_data);
            tx_count++;
        end
        if (!rst && done) begin
            dsrc_q.push_back(done_src);
            done_count++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for the given port's ready pulse, then drops its valid after the
    // accepting edge.
    task automatic waitAccept(input int port);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ((port == 0) ? req0_ready : req1_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                if (port == 0) req0_valid = 1'b0;
                else           req1_valid = 1'b0;
                break;
            end
            @(negedge clk);
        end
        checkOutput($sformatf("accept_p%0d", port), 32'(ok), 32'd1);
    endtask

    task automatic applyStimulus(input int port, input logic [1:0] id);
        @(negedge clk);
        if (port == 0) begin req0_id = id; req0_valid = 1'b1; end
        else           begin req1_id = id; req1_valid = 1'b1; end
        #1;
        waitAccept(port);
    endtask

    task automatic waitDoneCount(input int target, input int budget);
        for (int k = 0; k < budget && done_count < target; k++) @(posedge clk);
        checkOutput("done_count", done_count, target);
        #1;
        checkOutput("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic expectStr(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic expectCrlf();
`ifdef MSG_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic compareBytes(input string tag);
        int n;
        checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic clearLogs();
        got_q.delete();
        exp_q.delete();
        dsrc_q.delete();
    endtask

    // Directed test sequence
    initial begin
        int base;
        bit reached;
        checks = 0; errors = 0; tx_count = 0; done_count = 0;
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_id = '0; req1_id = '0; hold_busy = 1'b0;
        special_str = '0; special_len = '0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_rom_id", 32'(rom_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // PONG from requester 1
        clearLogs();
        base = done_count;
        applyStimulus(1, 2'd3);
        waitDoneCount(base + 1, 1000);
        expectStr("PONG"); expectCrlf();
        compareBytes("pong");
        checkOutput("pong_src", (dsrc_q.size() > 0) ? 32'(dsrc_q[0]) : 32'hDEAD, 32'd1);

        // Simultaneous requests: port 0 wins, then port 1 follows
        clearLogs();
        base = done_count;
        @(negedge clk);
        req0_id = 2'd2; req0_valid = 1'b1;
        req1_id = 2'd0; req1_valid = 1'b1;
        #1;
        checkOutput("tie_ready0", 32'(req0_ready), 32'd1);
        checkOutput("tie_ready1", 32'(req1_ready), 32'd0);
        waitAccept(0);
        waitAccept(1);
        waitDoneCount(base + 2, 3000);
        expectStr("error: invalid command"); expectCrlf();
        expectStr("starting program"); expectCrlf();
        compareBytes("tie");
        checkOutput("tie_src0", (dsrc_q.size() > 0) ? 32'(dsrc_q[0]) : 32'hDEAD, 32'd0);
        checkOutput("tie_src1", (dsrc_q.size() > 1) ? 32'(dsrc_q[1]) : 32'hDEAD, 32'd1);

        // Empty message
        clearLogs();
        base = done_count;
        special_len = 5'd0;
        applyStimulus(1, 2'd1);
`ifndef MSG_CRLF_EN
        @(negedge clk);
        checkOutput("len0_done_early", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("len0_done", 32'(done), 32'd1);
`endif
        waitDoneCount(base + 1, 500);
        expectCrlf();
        compareBytes("len0");

        // TX held busy while the sender sits in SEND
        clearLogs();
        base = tx_count;
        hold_busy = 1'b1;
        applyStimulus(1, 2'd3);
        repeat (50) @(negedge clk);
        checkOutput("hold_no_start", tx_count - base, 0);
        checkOutput("hold_busy_out", 32'(busy), 32'd1);
        hold_busy = 1'b0;
        @(negedge clk);
        checkOutput("hold_release_start", 32'(tx_start), 32'd1);
        waitDoneCount(done_count + 1, 1000);
        expectStr("PONG"); expectCrlf();
        compareBytes("hold");

        // Asynchronous reset after two of four bytes
        clearLogs();
        base = done_count;
        tx_count = 0;
        applyStimulus(0, 2'd3);
        reached = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            if (tx_count >= 2) begin reached = 1'b1; break; end
        end
        checkOutput("abort_reached", 32'(reached), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("abort_tx_start", 32'(tx_start), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("abort_tx_count", tx_count, 2);
        checkOutput("abort_no_done", done_count, base);
        clearLogs();
        applyStimulus(0, 2'd3);
        waitDoneCount(base + 1, 1000);
        expectStr("PONG"); expectCrlf();
        compareBytes("after_rst");

        // Longest message: 31 ascending characters
        clearLogs();
        base = done_count;
        for (int i = 0; i < 31; i++) special_str[8*(30-i) +: 8] = 8'(8'h41 + i);
        special_len = 5'd31;
        applyStimulus(0, 2'd1);
        waitDoneCount(base + 1, 3000);
        for (int i = 0; i < 31; i++) exp_q.push_back(8'(8'h41 + i));
        expectCrlf();
        compareBytes("len31");

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
